irq_controller: RTL and testbench
=================================

Name: irq_controller

Overview:
- Machine-level interrupt controller for the rv32i core.
- Owns the mie (0x304) and mip (0x344) CSRs, synchronises the external, timer and software interrupt lines, and picks the highest-priority enabled interrupt.
- Presents that interrupt to the execute stage as an encoded cause over a req/ack handshake. The execute stage forwards it to cs_registers as jump_to_trap/excp_cause.
- Holds off re-requests after each ack until the mstatus.MIE update has settled.

Parameters:
- SYNC_STAGES, 2, flops per asynchronous interrupt line (allowed 2..3)
- HOLDOFF_CYCLES, 2, cycles after ack before a new request may be raised (allowed 1..7)

Ports:
- clk_i  in  1  core clock
- resetb_i  in  1  reset, synchronous, active-low
- clk_en_i  in  1  global clock enable; all state frozen when low
- exs_en_i  in  1  execute stage enable; qualifies CSR reads/writes
- ext_irq_i  in  1  machine external interrupt, asynchronous level
- timer_irq_i  in  1  machine timer interrupt, asynchronous level
- soft_irq_i  in  1  machine software interrupt, asynchronous level
- mode_i  in  2  current privilege mode (from cs_registers mode_o)
- mstatus_mie_i  in  1  mstatus.MIE
- addr_i  in  12  CSR read address
- rd_i  in  1  CSR read strobe
- hit_o  out  1  registered; addr_i decoded to 0x304 or 0x344
- rd_data_o  out  32  registered CSR read data
- wr_i  in  1  CSR write, already exception-gated
- wr_mode_i  in  2  01 write, 10 set, 11 clear; 00 no-op
- wr_addr_i  in  12  CSR write address
- wr_data_i  in  32  CSR write operand
- irq_req_o  out  1  interrupt request to execute stage
- irq_cause_o  out  32  encoded cause; valid while irq_req_o is high
- irq_ack_i  in  1  pipeline took the trap (jump_to_trap with exs_en)

Behaviour:
- Clock and reset: one clock, clk_i. Reset resetb_i is synchronous and active-low.
- Reset values: mie=0, sync flops=0, state=IDLE, irq_req_o=0, irq_cause_o=0, hit_o=0, rd_data_o=0, holdoff counter=0.
- clk_en_i low: no register changes, including the synchronisers.
- Synchronisation: each irq line passes through SYNC_STAGES flops. mip.MEIP(11), mip.MTIP(7), mip.MSIP(3) are the synchroniser outputs. Total latency from input edge to mip is SYNC_STAGES cycles.
- mie:
  - Writable bits are 11, 7 and 3; all others read 0 (WARL).
  - A write, set or clear applies when clk_en_i & exs_en_i & wr_i and wr_addr_i==0x304.
  - Set and clear use the current mie value as the old value.
- mip: read-only in this block. Writes to 0x344 are ignored; no error is raised here.
- Read path: when clk_en_i & exs_en_i & rd_i, the following are registered one cycle later:
  - rd_data_o: mie, mip, or 0.
  - hit_o: asserted for 0x304 or 0x344.
- Global enable: gen = (mode_i != M) | mstatus_mie_i.
- Candidate set: pend = mip & mie & {gen}. Priority is MEI(11) > MSI(3) > MTI(7).
- Cause encoding: {1'b1, 27'b0, code[3:0]}.
- State machine:
  - IDLE: if pend != 0, go to REQ; irq_req_o=1 and irq_cause_o is latched to the winning cause on the same clock edge.
  - REQ:
    - irq_cause_o is frozen; a higher-priority arrival does not change it.
    - If irq_ack_i: go to HOLD, irq_req_o=0, load the holdoff counter with HOLDOFF_CYCLES.
    - Else if the latched source's bit in pend is 0 (line dropped, mie cleared, or gen low): withdraw to IDLE with irq_req_o=0.
    - Ack wins over a simultaneous withdrawal.
  - HOLD: decrement the counter each enabled cycle. At 0, go to IDLE. irq_req_o stays 0 throughout, whatever pend is.
- Simultaneous events:
  - A CSR write to mie in the same cycle as the IDLE->REQ evaluation: the evaluation uses the pre-write mie.
  - irq_ack_i in IDLE or HOLD is ignored.
- Reset asserted mid-REQ: request drops on the next edge; no ack is expected.

Decomposition:
- Add to riscv_defs.v:
  - RV_IRQ_CODE_MEI=11, RV_IRQ_CODE_MSI=3, RV_IRQ_CODE_MTI=7
  - RV_MIE_LEGAL_MASK=32'h888
  - RV_CSR_ADDR_MIE, RV_CSR_ADDR_MIP
  - state encodings
- Sub-module irq_sync: a SYNC_STAGES-deep flop chain with clk_en and synchronous reset, instantiated three times.

Test Plan:
- Reset, then mie=0x888, M-mode, mstatus_mie_i=1; pulse timer_irq_i high → irq_req_o rises SYNC_STAGES+1 cycles later, irq_cause_o=0x80000007.
- ext_irq_i and timer_irq_i asserted together → irq_cause_o=0x8000000B. Then raise soft_irq_i while in REQ → cause stays 0x8000000B until ack.
- In REQ, clear mie via wr_mode 11, data 0x800 → irq_req_o drops next cycle with no ack. Re-enable → request is re-raised.
- Ack with the line still high → irq_req_o low for exactly HOLDOFF_CYCLES+1 cycles, then re-asserts only if mstatus_mie_i=1.
- mode_i=U, mstatus_mie_i=0, mie.MSIE=1, soft_irq_i=1 → request with cause 0x80000003. Same stimulus in M-mode → no request.
- Read 0x344 with only the timer line high → hit_o=1, rd_data_o=0x080. Read 0x300 → hit_o=0. Write 0x344 → mip unchanged.

Source files
------------

// File: rtl/irq_controller_pkg.sv
// Shared constants, state encodings and helpers for the machine-level interrupt controller.
package irq_controller_pkg;

   localparam logic [3:0]  RV_IRQ_CODE_MEI   = 4'd11;
   localparam logic [3:0]  RV_IRQ_CODE_MSI   = 4'd3;
   localparam logic [3:0]  RV_IRQ_CODE_MTI   = 4'd7;
   localparam logic [31:0] RV_MIE_LEGAL_MASK = 32'h0000_0888;
   localparam logic [11:0] RV_CSR_ADDR_MIE   = 12'h304;
   localparam logic [11:0] RV_CSR_ADDR_MIP   = 12'h344;
   localparam logic [1:0]  RV_PRIV_M         = 2'b11;

   typedef enum logic [1:0] {
      CSR_WR_NONE  = 2'b00,
      CSR_WR_WRITE = 2'b01,
      CSR_WR_SET   = 2'b10,
      CSR_WR_CLEAR = 2'b11
   } csr_wr_mode_e;

   typedef enum logic [1:0] {
      IRQ_IDLE = 2'b00,
      IRQ_REQ  = 2'b01,
      IRQ_HOLD = 2'b10
   } irq_state_e;

   // Caller guarantees at least one source is pending; MTI is the fallback.
   function automatic logic [3:0] irq_winner(input logic mei, input logic msi);
      if (mei)
         return RV_IRQ_CODE_MEI;
      else if (msi)
         return RV_IRQ_CODE_MSI;
      else
         return RV_IRQ_CODE_MTI;
   endfunction

   function automatic logic [31:0] irq_cause(input logic [3:0] code);
      return {1'b1, 27'b0, code};
   endfunction

endpackage

// File: rtl/irq_controller_sync.sv
// Clock-enabled flop chain bringing one asynchronous interrupt level into clk_i.
module irq_sync #(
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic clk_i,
   input  logic resetb_i,
   input  logic clk_en_i,
   input  logic async_i,
   output logic sync_o
);

   logic [SYNC_STAGES-1:0] chain_q;

   always_ff @(posedge clk_i) begin
      if (!resetb_i)
         chain_q <= '0;
      else if (clk_en_i)
         chain_q <= {chain_q[SYNC_STAGES-2:0], async_i};
   end

   assign sync_o = chain_q[SYNC_STAGES-1];

endmodule

// File: rtl/irq_controller.sv
// Machine interrupt controller: owns mie/mip, synchronises irq lines and raises a
// prioritised cause to the execute stage over a req/ack handshake with post-ack holdoff.
module irq_controller
   import irq_controller_pkg::*;
#(
   parameter int unsigned SYNC_STAGES    = 2,
   parameter int unsigned HOLDOFF_CYCLES = 2
) (
   input  logic        clk_i,
   input  logic        resetb_i,
   input  logic        clk_en_i,
   input  logic        exs_en_i,
   input  logic        ext_irq_i,
   input  logic        timer_irq_i,
   input  logic        soft_irq_i,
   input  logic [1:0]  mode_i,
   input  logic        mstatus_mie_i,
   input  logic [11:0] addr_i,
   input  logic        rd_i,
   output logic        hit_o,
   output logic [31:0] rd_data_o,
   input  logic        wr_i,
   input  logic [1:0]  wr_mode_i,
   input  logic [11:0] wr_addr_i,
   input  logic [31:0] wr_data_i,
   output logic        irq_req_o,
   output logic [31:0] irq_cause_o,
   input  logic        irq_ack_i
);

   localparam logic [2:0] HOLD_LOAD = 3'(HOLDOFF_CYCLES);

   logic        meip, mtip, msip;
   logic [31:0] mie_q, mie_nxt;
   logic [31:0] mip, pend, rd_mux;
   logic        gen;
   irq_state_e  state_q, state_nxt;
   logic        req_nxt;
   logic [31:0] cause_nxt;
   logic [2:0]  hold_q, hold_nxt;

   irq_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_ext (
      .clk_i    (clk_i),
      .resetb_i (resetb_i),
      .clk_en_i (clk_en_i),
      .async_i  (ext_irq_i),
      .sync_o   (meip)
   );

   irq_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_timer (
      .clk_i    (clk_i),
      .resetb_i (resetb_i),
      .clk_en_i (clk_en_i),
      .async_i  (timer_irq_i),
      .sync_o   (mtip)
   );

   irq_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_soft (
      .clk_i    (clk_i),
      .resetb_i (resetb_i),
      .clk_en_i (clk_en_i),
      .async_i  (soft_irq_i),
      .sync_o   (msip)
   );

   always_comb begin
      mip     = '0;
      mip[11] = meip;
      mip[7]  = mtip;
      mip[3]  = msip;
   end

   assign gen  = (mode_i != RV_PRIV_M) | mstatus_mie_i;
   assign pend = mip & mie_q & {32{gen}};

   always_comb begin
      mie_nxt = mie_q;
      if (exs_en_i && wr_i && (wr_addr_i == RV_CSR_ADDR_MIE)) begin
         case (csr_wr_mode_e'(wr_mode_i))
            CSR_WR_WRITE: mie_nxt = wr_data_i & RV_MIE_LEGAL_MASK;
            CSR_WR_SET:   mie_nxt = (mie_q | wr_data_i) & RV_MIE_LEGAL_MASK;
            CSR_WR_CLEAR: mie_nxt = mie_q & ~wr_data_i & RV_MIE_LEGAL_MASK;
            default:      mie_nxt = mie_q;
         endcase
      end
   end

   always_comb begin
      rd_mux = '0;
      if (addr_i == RV_CSR_ADDR_MIE)
         rd_mux = mie_q;
      else if (addr_i == RV_CSR_ADDR_MIP)
         rd_mux = mip;
   end

   always_comb begin
      state_nxt = state_q;
      req_nxt   = irq_req_o;
      cause_nxt = irq_cause_o;
      hold_nxt  = hold_q;
      case (state_q)
         IRQ_IDLE: begin
            if (|pend) begin
               state_nxt = IRQ_REQ;
               req_nxt   = 1'b1;
               cause_nxt = irq_cause(irq_winner(pend[11], pend[3]));
            end
         end
         IRQ_REQ: begin
            // Cause code equals its mip/mie bit index, so it selects the latched source directly.
            if (irq_ack_i) begin
               state_nxt = IRQ_HOLD;
               req_nxt   = 1'b0;
               hold_nxt  = HOLD_LOAD;
            end else if (!pend[irq_cause_o[3:0]]) begin
               state_nxt = IRQ_IDLE;
               req_nxt   = 1'b0;
            end
         end
         IRQ_HOLD: begin
            req_nxt  = 1'b0;
            hold_nxt = hold_q - 3'd1;
            if (hold_q <= 3'd1) begin
               state_nxt = IRQ_IDLE;
               hold_nxt  = '0;
            end
         end
         default: begin
            state_nxt = IRQ_IDLE;
            req_nxt   = 1'b0;
            hold_nxt  = '0;
         end
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (!resetb_i) begin
         mie_q       <= '0;
         state_q     <= IRQ_IDLE;
         irq_req_o   <= 1'b0;
         irq_cause_o <= '0;
         hold_q      <= '0;
         hit_o       <= 1'b0;
         rd_data_o   <= '0;
      end else if (clk_en_i) begin
         mie_q       <= mie_nxt;
         state_q     <= state_nxt;
         irq_req_o   <= req_nxt;
         irq_cause_o <= cause_nxt;
         hold_q      <= hold_nxt;
         if (exs_en_i && rd_i) begin
            hit_o     <= (addr_i == RV_CSR_ADDR_MIE) || (addr_i == RV_CSR_ADDR_MIP);
            rd_data_o <= rd_mux;
         end
      end
   end

endmodule

// File: tb/tb_irq_controller.sv
// Randomised scoreboard bench for irq_controller against a cycle-level behavioural model.
module tb_irq_controller;

   localparam int unsigned SYNC = 2;
   localparam int unsigned HOLD = 3;

   logic        clk_i = 1'b0;
   logic        resetb_i, clk_en_i, exs_en_i;
   logic        ext_irq_i, timer_irq_i, soft_irq_i;
   logic [1:0]  mode_i;
   logic        mstatus_mie_i;
   logic [11:0] addr_i;
   logic        rd_i;
   logic        hit_o;
   logic [31:0] rd_data_o;
   logic        wr_i;
   logic [1:0]  wr_mode_i;
   logic [11:0] wr_addr_i;
   logic [31:0] wr_data_i;
   logic        irq_req_o;
   logic [31:0] irq_cause_o;
   logic        irq_ack_i;

   always #5 clk_i = ~clk_i;

   irq_controller #(.SYNC_STAGES(SYNC), .HOLDOFF_CYCLES(HOLD)) dut (
      .clk_i         (clk_i),
      .resetb_i      (resetb_i),
      .clk_en_i      (clk_en_i),
      .exs_en_i      (exs_en_i),
      .ext_irq_i     (ext_irq_i),
      .timer_irq_i   (timer_irq_i),
      .soft_irq_i    (soft_irq_i),
      .mode_i        (mode_i),
      .mstatus_mie_i (mstatus_mie_i),
      .addr_i        (addr_i),
      .rd_i          (rd_i),
      .hit_o         (hit_o),
      .rd_data_o     (rd_data_o),
      .wr_i          (wr_i),
      .wr_mode_i     (wr_mode_i),
      .wr_addr_i     (wr_addr_i),
      .wr_data_i     (wr_data_i),
      .irq_req_o     (irq_req_o),
      .irq_cause_o   (irq_cause_o),
      .irq_ack_i     (irq_ack_i)
   );

   typedef struct {
      logic        req;
      logic [31:0] cause;
      logic        hit;
      logic [31:0] rd;
   } exp_t;

   exp_t sb[$];
   int   checks = 0;
   int   errors = 0;

   // Reference model: mip is the input sample taken SYNC enabled edges ago; a request
   // is a pending/acked/holding-off flag plus a remaining-holdoff count.
   logic [31:0] m_mie, m_cause, m_rd;
   logic [2:0]  m_hist[$];
   logic        m_req, m_hit;
   int          m_hold;

   function automatic logic [31:0] model_mip();
      logic [2:0]  s;
      logic [31:0] r;
      s = m_hist[SYNC-1];
      r = '0;
      if (s[2]) r = r | 32'h800;
      if (s[1]) r = r | 32'h080;
      if (s[0]) r = r | 32'h008;
      return r;
   endfunction

   task automatic step();
      logic [31:0] mip, pend;
      logic        gen, found;
      int          prio[3];
      exp_t        e;
      prio = '{11, 3, 7};
      if (!resetb_i) begin
         m_mie = '0; m_req = 1'b0; m_cause = '0; m_hold = 0; m_hit = 1'b0; m_rd = '0;
         m_hist = {};
         for (int unsigned i = 0; i < SYNC; i++) m_hist.push_back(3'b000);
      end else if (clk_en_i) begin
         mip  = model_mip();
         gen  = (mode_i != 2'b11) || mstatus_mie_i;
         pend = gen ? (mip & m_mie) : 32'h0;
         if (m_hold > 0) begin
            m_hold--;
         end else if (m_req) begin
            if (irq_ack_i) begin
               m_req  = 1'b0;
               m_hold = HOLD;
            end else if (!pend[m_cause[3:0]]) begin
               m_req = 1'b0;
            end
         end else if (pend != 0) begin
            found = 1'b0;
            for (int i = 0; i < 3; i++)
               if (!found && pend[prio[i]]) begin
                  m_cause = 32'h8000_0000 | 32'(prio[i]);
                  found   = 1'b1;
               end
            m_req = 1'b1;
         end
         if (exs_en_i && rd_i) begin
            m_hit = (addr_i == 12'h304) || (addr_i == 12'h344);
            m_rd  = (addr_i == 12'h304) ? m_mie : (addr_i == 12'h344) ? mip : 32'h0;
         end
         if (exs_en_i && wr_i && wr_addr_i == 12'h304) begin
            case (wr_mode_i)
               2'b01:   m_mie = wr_data_i & 32'h888;
               2'b10:   m_mie = m_mie | (wr_data_i & 32'h888);
               2'b11:   m_mie = m_mie & ~wr_data_i;
               default: ;
            endcase
         end
         m_hist.push_front({ext_irq_i, timer_irq_i, soft_irq_i});
         void'(m_hist.pop_back());
      end
      e.req = m_req; e.cause = m_cause; e.hit = m_hit; e.rd = m_rd;
      sb.push_back(e);
      @(negedge clk_i);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   initial begin : monitor
      exp_t e;
      forever begin
         @(negedge clk_i);
         if (sb.size() > 0) begin
            e = sb.pop_front();
            chk("irq_req",   {31'b0, irq_req_o}, {31'b0, e.req});
            chk("irq_cause", irq_cause_o,        e.cause);
            chk("hit",       {31'b0, hit_o},     {31'b0, e.hit});
            chk("rd_data",   rd_data_o,          e.rd);
         end
      end
   end

   task automatic idle(input int n);
      repeat (n) step();
   endtask

   task automatic csr_wr(input logic [1:0] mode, input logic [11:0] a, input logic [31:0] d);
      wr_i = 1'b1; wr_mode_i = mode; wr_addr_i = a; wr_data_i = d;
      step();
      wr_i = 1'b0; wr_mode_i = 2'b00;
   endtask

   task automatic csr_rd(input logic [11:0] a);
      rd_i = 1'b1; addr_i = a;
      step();
      rd_i = 1'b0;
   endtask

   task automatic ack();
      irq_ack_i = 1'b1;
      step();
      irq_ack_i = 1'b0;
   endtask

   function automatic logic [11:0] pick_addr();
      case ($urandom_range(0, 3))
         0:       return 12'h304;
         1:       return 12'h344;
         2:       return 12'h300;
         default: return 12'($urandom);
      endcase
   endfunction

   initial begin
      resetb_i = 1'b0; clk_en_i = 1'b1; exs_en_i = 1'b1;
      ext_irq_i = 1'b0; timer_irq_i = 1'b0; soft_irq_i = 1'b0;
      mode_i = 2'b11; mstatus_mie_i = 1'b1;
      addr_i = '0; rd_i = 1'b0; wr_i = 1'b0; wr_mode_i = 2'b00;
      wr_addr_i = '0; wr_data_i = '0; irq_ack_i = 1'b0;
      idle(3);
      resetb_i = 1'b1;
      idle(1);

      // timer pulse, then ack
      csr_wr(2'b01, 12'h304, 32'hFFFF_FFFF);
      timer_irq_i = 1'b1; idle(5);
      ack(); timer_irq_i = 1'b0; idle(6);

      // ext + timer together, then soft during REQ
      ext_irq_i = 1'b1; timer_irq_i = 1'b1; idle(4);
      soft_irq_i = 1'b1; idle(3);
      ack(); ext_irq_i = 1'b0; timer_irq_i = 1'b0; soft_irq_i = 1'b0; idle(6);

      // withdraw by clearing MEIE, re-raise by setting it
      ext_irq_i = 1'b1; idle(4);
      csr_wr(2'b11, 12'h304, 32'h800); idle(3);
      csr_wr(2'b10, 12'h304, 32'h800); idle(3);

      // ack with line still high: holdoff then re-request; then ack with MIE off
      ack(); idle(7);
      mstatus_mie_i = 1'b0; ack(); idle(8);
      ext_irq_i = 1'b0; mstatus_mie_i = 1'b1; idle(4);

      // U-mode ignores mstatus.MIE; M-mode with MIE off withdraws
      csr_wr(2'b01, 12'h304, 32'h008);
      mode_i = 2'b00; mstatus_mie_i = 1'b0; soft_irq_i = 1'b1; idle(5);
      mode_i = 2'b11; idle(4);
      soft_irq_i = 1'b0; idle(3);

      // CSR reads, write to mip ignored, exs_en gating
      csr_wr(2'b01, 12'h304, 32'h888);
      mstatus_mie_i = 1'b0; timer_irq_i = 1'b1; idle(4);
      csr_rd(12'h344); csr_rd(12'h300); csr_rd(12'h304);
      csr_wr(2'b01, 12'h344, 32'hFFFF_FFFF); csr_rd(12'h344);
      exs_en_i = 1'b0; csr_wr(2'b01, 12'h304, 32'h0); csr_rd(12'h300); exs_en_i = 1'b1;
      csr_rd(12'h304);

      // clock enable freeze and reset mid-REQ
      clk_en_i = 1'b0; ext_irq_i = 1'b1; idle(4); clk_en_i = 1'b1;
      mstatus_mie_i = 1'b1; idle(4);
      resetb_i = 1'b0; idle(1); resetb_i = 1'b1; idle(4);
      timer_irq_i = 1'b0; ext_irq_i = 1'b0;
      csr_wr(2'b01, 12'h304, 32'h888);

      for (int n = 0; n < 3000; n++) begin
         resetb_i  = ($urandom_range(0, 499) != 0);
         clk_en_i  = ($urandom_range(0, 9) != 0);
         exs_en_i  = ($urandom_range(0, 9) != 0);
         if ($urandom_range(0, 15) == 0) ext_irq_i   = ~ext_irq_i;
         if ($urandom_range(0, 15) == 0) timer_irq_i = ~timer_irq_i;
         if ($urandom_range(0, 15) == 0) soft_irq_i  = ~soft_irq_i;
         if ($urandom_range(0, 39) == 0) mode_i = (mode_i == 2'b11) ? 2'b00 : 2'b11;
         if ($urandom_range(0, 29) == 0) mstatus_mie_i = ~mstatus_mie_i;
         wr_i      = ($urandom_range(0, 11) == 0);
         wr_mode_i = 2'($urandom_range(0, 3));
         wr_addr_i = pick_addr();
         wr_data_i = $urandom;
         rd_i      = ($urandom_range(0, 3) == 0);
         addr_i    = pick_addr();
         irq_ack_i = m_req ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 15) == 0);
         step();
      end
      wr_i = 1'b0; rd_i = 1'b0; irq_ack_i = 1'b0; resetb_i = 1'b1; clk_en_i = 1'b1;
      idle(2);
      @(negedge clk_i);
      #2;
      chk("scoreboard_drained", 32'(sb.size()), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
